// File: rtl/frame_save_pkg.sv
// Shared state encoding and default constants for the frame-to-SD save controller.
package frame_save_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  localparam logic [31:0] DEF_SECTOR_BASE = 32'd1000;
  localparam int unsigned DEF_SECTOR_NUM  = 32'd3600;
  localparam int unsigned DEF_BUSY_TMO    = 32'd1000;
  localparam int unsigned SEC_CNT_W       = 32'd12;

  // The SDRAM read port belongs to the SD writer only while sectors are being pushed.
  function automatic logic routes_sd(input state_e s);
    case (s)
      ST_ISSUE, ST_WAIT_HI, ST_WAIT_LO, ST_NEXT: routes_sd = 1'b1;
      default:                                   routes_sd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_save_ctrl.sv
// Sequences one full-frame save to SD: waits for a frame boundary, then issues
// SECTOR_NUM sector writes, handshaking each one on wr_busy with a rise timeout.
module frame_save_ctrl
  import frame_save_pkg::*;
#(
  parameter logic [31:0] SECTOR_BASE = DEF_SECTOR_BASE,
  parameter int unsigned SECTOR_NUM  = DEF_SECTOR_NUM,
  parameter int unsigned BUSY_TMO    = DEF_BUSY_TMO
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 key_flag,
  input  logic                 sd_init_end,
  input  logic                 frame_start,
  input  logic                 wr_busy,
  output logic                 wr_en,
  output logic [31:0]          wr_addr,
  output logic                 src_sel,
  output logic [SEC_CNT_W-1:0] sec_cnt,
  output logic                 save_done,
  output logic                 save_err
);

  localparam int unsigned TMO_W = (BUSY_TMO > 32'd1) ? $clog2(BUSY_TMO) : 32'd1;
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(BUSY_TMO - 32'd1);
  localparam logic [TMO_W-1:0]     TMO_ONE   = TMO_W'(32'd1);
  localparam logic [SEC_CNT_W-1:0] SEC_TOTAL = SEC_CNT_W'(SECTOR_NUM);

  state_e                 state_q, state_d;
  logic                   wr_en_q, wr_en_d;
  logic [31:0]            wr_addr_q, wr_addr_d;
  logic                   src_sel_q, src_sel_d;
  logic [SEC_CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic                   save_done_q, save_done_d;
  logic                   save_err_q, save_err_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  // Next-state and next-output computation for the save sequencer.
  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    sec_cnt_d   = sec_cnt_q;
    save_err_d  = save_err_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (key_flag && sd_init_end) begin
          state_d    = ST_ARM;
          save_err_d = 1'b0;
          sec_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (frame_start) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_ISSUE: begin
        // A writer still busy from the previous sector must drain before the next start.
        if (!wr_busy) begin
          wr_en_d   = 1'b1;
          wr_addr_d = SECTOR_BASE + 32'(sec_cnt_q);
          tmo_d     = '0;
          state_d   = ST_WAIT_HI;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_HI: begin
        if (wr_busy) begin
          state_d = ST_WAIT_LO;
        end else if (tmo_q >= TMO_LAST) begin
          state_d    = ST_ERR;
          save_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (!wr_busy) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_NEXT: begin
        sec_cnt_d = sec_cnt_q + 12'd1;
        if (sec_cnt_d == SEC_TOTAL) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    save_done_d = (state_d == ST_DONE);
    src_sel_d   = routes_sd(state_d);
  end

  // State and registered outputs, with synchronous reset abandoning any save.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 32'd0;
      src_sel_q   <= 1'b0;
      sec_cnt_q   <= '0;
      save_done_q <= 1'b0;
      save_err_q  <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      src_sel_q   <= src_sel_d;
      sec_cnt_q   <= sec_cnt_d;
      save_done_q <= save_done_d;
      save_err_q  <= save_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign src_sel   = src_sel_q;
  assign sec_cnt   = sec_cnt_q;
  assign save_done = save_done_q;
  assign save_err  = save_err_q;

endmodule

// File: tb/tb_frame_save_ctrl.sv
// Scoreboard bench for frame_save_ctrl: four-sector frames, ten-cycle busy timeout.
module tb_frame_save_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        key_flag;
  logic        sd_init_end;
  logic        frame_start;
  logic        wr_busy;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic        src_sel;
  logic [11:0] sec_cnt;
  logic        save_done;
  logic        save_err;

  logic busy_auto;
  logic busy_force;
  logic busy_model;

  int checks = 0;
  int errors = 0;
  int wr_en_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_done_q[$];

  assign wr_busy = busy_auto ? busy_model : busy_force;

  always #5 clk = ~clk;

  frame_save_ctrl #(
    .SECTOR_BASE(32'd1000),
    .SECTOR_NUM (32'd4),
    .BUSY_TMO   (32'd10)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .key_flag   (key_flag),
    .sd_init_end(sd_init_end),
    .frame_start(frame_start),
    .wr_busy    (wr_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .src_sel    (src_sel),
    .sec_cnt    (sec_cnt),
    .save_done  (save_done),
    .save_err   (save_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // SD writer model: busy rises 3 cycles after wr_en and falls 20 cycles later.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_auto && wr_en) begin
        repeat (3) @(posedge clk);
        #2 busy_model = 1'b1;
        repeat (20) @(posedge clk);
        #2 busy_model = 1'b0;
      end
    end
  end

  // Output monitor: pops expected sector addresses and done pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        wr_en_cnt++;
        chk("wr_en_src_sel", src_sel, 1);
        if (exp_addr_q.size() == 0) chk("wr_en_unexpected", 32'(exp_addr_q.size()), 32'd1);
        else chk("wr_addr", wr_addr, exp_addr_q.pop_front());
      end
      if (save_done) begin
        done_cnt++;
        chk("done_src_sel", src_sel, 0);
        if (exp_done_q.size() == 0) chk("done_unexpected", 32'(exp_done_q.size()), 32'd1);
        else chk("done_sec_cnt", sec_cnt, exp_done_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic pulse_key();
    @(negedge clk) key_flag = 1'b1;
    @(negedge clk) key_flag = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic wait_wr_en(input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      seen = wr_en;
      n++;
    end
    chk("wr_en_wait", seen, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done_cnt, target);
  endtask

  task automatic push_frame();
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'd1000 + 32'(i));
    exp_done_q.push_back(32'd4);
  endtask

  task automatic run_save(input logic extra);
    int base;
    int d0;
    base = wr_en_cnt;
    d0   = done_cnt;
    push_frame();
    pulse_key();
    chk("key_clears_err", save_err, 0);
    chk("key_clears_cnt", sec_cnt, 0);
    repeat (2) @(negedge clk);
    chk("arm_src_sel", src_sel, 0);
    pulse_frame();
    chk("issue_src_sel", src_sel, 1);
    if (extra) begin
      wait_wr_en(50);
      pulse_key();
      pulse_frame();
    end
    wait_done(d0 + 1, 400);
    @(negedge clk);
    chk("save_wr_en_total", wr_en_cnt - base, 4);
    chk("save_sec_cnt", sec_cnt, 4);
    chk("save_src_sel_after", src_sel, 0);
    chk("save_addr_q_empty", 32'(exp_addr_q.size()), 0);
  endtask

  initial begin
    int base;
    int d0;
    sys_rst     = 1'b1;
    key_flag    = 1'b0;
    sd_init_end = 1'b1;
    frame_start = 1'b0;
    busy_auto   = 1'b0;
    busy_force  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_flags", {wr_en, src_sel, save_done, save_err}, 0);
    chk("rst_sec_cnt", sec_cnt, 0);
    chk("rst_wr_addr", wr_addr, 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Capture request before SD init must be ignored, as must a stray frame boundary.
    sd_init_end = 1'b0;
    base = wr_en_cnt;
    pulse_key();
    pulse_frame();
    repeat (10) @(negedge clk);
    chk("noinit_wr_en", wr_en_cnt - base, 0);
    chk("noinit_src_sel", src_sel, 0);
    sd_init_end = 1'b1;

    busy_auto = 1'b1;
    run_save(1'b0);

    // Writer still busy on entry to ISSUE: no start until it drops.
    busy_auto  = 1'b0;
    busy_force = 1'b1;
    base = wr_en_cnt;
    d0   = done_cnt;
    push_frame();
    pulse_key();
    pulse_frame();
    repeat (5) @(negedge clk);
    chk("held_busy_no_wr_en", wr_en_cnt - base, 0);
    chk("held_busy_src_sel", src_sel, 1);
    busy_force = 1'b0;
    wait_wr_en(20);
    @(negedge clk);
    chk("held_busy_single", wr_en_cnt - base, 1);
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    busy_auto = 1'b1;
    wait_done(d0 + 1, 400);
    @(negedge clk);
    chk("held_busy_total", wr_en_cnt - base, 4);

    // Busy never rises: error exactly 10 cycles after the start pulse.
    busy_auto  = 1'b0;
    busy_force = 1'b0;
    d0 = done_cnt;
    exp_addr_q.push_back(32'd1000);
    pulse_key();
    pulse_frame();
    wait_wr_en(20);
    repeat (9) @(posedge clk);
    #1;
    chk("tmo_err_early", save_err, 0);
    chk("tmo_src_sel_early", src_sel, 1);
    @(posedge clk);
    #1;
    chk("tmo_err", save_err, 1);
    chk("tmo_src_sel", src_sel, 0);
    repeat (5) @(negedge clk);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_err_sticky", save_err, 1);

    // Next accepted key clears the error; extra key/frame mid-save are ignored.
    busy_auto = 1'b1;
    run_save(1'b1);

    // Reset during WAIT_LO of the second sector.
    d0 = done_cnt;
    push_frame();
    pulse_key();
    pulse_frame();
    wait_wr_en(50);
    wait_wr_en(50);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", wr_busy, 1);
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_flags", {wr_en, src_sel, save_done, save_err}, 0);
    chk("midrst_sec_cnt", sec_cnt, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    exp_addr_q.delete();
    exp_done_q.delete();
    @(negedge clk) sys_rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_save(1'b0);

    repeat (5) @(negedge clk);
    chk("end_addr_q_empty", 32'(exp_addr_q.size()), 0);
    chk("end_done_q_empty", 32'(exp_done_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_save_ctrl.md
FRAME_SAVE_CTRL -- requirements
Module: frame_save_ctrl

Interface
REQ-001 SHALL have parameter SECTOR_BASE, default 32'd1000, first SD sector address of the saved frame.
REQ-002 SHALL have parameter SECTOR_NUM, default 3600, sectors per frame (1280x720x2 bytes / 512).
REQ-003 SHALL have parameter BUSY_TMO, default 1000, max cycles from wr_en pulse to wr_busy rising.
REQ-004 SHALL have port sys_clk  in  1  single clock, 50 MHz domain.
REQ-005 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port key_flag  in  1  one-cycle capture request from the debouncer.
REQ-007 SHALL have port sd_init_end  in  1  SD card initialised.
REQ-008 SHALL have port frame_start  in  1  one-cycle pulse at SDRAM read-frame boundary.
REQ-009 SHALL have port wr_busy  in  1  SD write in progress.
REQ-010 SHALL have port wr_en  out  1  one-cycle SD sector write start.
REQ-011 SHALL have port wr_addr  out  32  SD sector address, valid while wr_en high and until next wr_en.
REQ-012 SHALL have port src_sel  out  1  1 = SDRAM read port routed to SD writer, 0 = display.
REQ-013 SHALL have port sec_cnt  out  12  sectors completed in the current save.
REQ-014 SHALL have port save_done  out  1  one-cycle pulse on successful save.
REQ-015 SHALL have port save_err  out  1  sticky; set on busy timeout, cleared by next accepted key_flag.

Function
REQ-016 SHALL implement states IDLE, ARM, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE, ERR.
REQ-017 IDLE: key_flag=1 and sd_init_end=1 -> ARM, clear save_err and sec_cnt; key_flag with sd_init_end=0 SHALL be ignored.
REQ-018 ARM: hold src_sel=0; on frame_start -> ISSUE, src_sel=1 in the next cycle.
REQ-019 ISSUE: if wr_busy=1, remain in ISSUE without pulsing; else assert wr_en for exactly one cycle with wr_addr=SECTOR_BASE+sec_cnt, -> WAIT_HI.
REQ-020 WAIT_HI: wr_busy=1 -> WAIT_LO; timeout counter reaching BUSY_TMO cycles -> ERR.
REQ-021 WAIT_LO: wr_busy falling -> NEXT; no timeout applies.
REQ-022 NEXT: sec_cnt+1; if new value equals SECTOR_NUM -> DONE, else -> ISSUE (one cycle in NEXT).
REQ-023 DONE: save_done=1 for one cycle, src_sel=0, -> IDLE.
REQ-024 ERR: save_err=1, src_sel=0, wr_en=0, -> IDLE next cycle.
REQ-025 key_flag in any state other than IDLE SHALL be ignored; frame_start outside ARM SHALL be ignored.
REQ-026 wr_addr arithmetic SHALL be 32-bit unsigned, modulo 2^32; sec_cnt SHALL never exceed SECTOR_NUM.
REQ-027 Timeout counter SHALL be cleared on entry to WAIT_HI and SHALL not wrap.
REQ-028 src_sel SHALL be 1 only in ISSUE, WAIT_HI, WAIT_LO, NEXT.

Reset
REQ-029 sys_rst=1 at a clock edge SHALL force IDLE, wr_en=0, wr_addr=0, src_sel=0, sec_cnt=0, save_done=0, save_err=0, timeout counter=0.
REQ-030 Reset mid-save SHALL abandon the save with no save_done pulse; src_sel SHALL be 0 in the first post-reset cycle.

Structure
REQ-031 State encoding and default constants (SECTOR_BASE, SECTOR_NUM, BUSY_TMO) SHALL live in a shared package, frame_save_pkg.
REQ-032 No sub-module is required; the timeout counter SHALL be inline.

Verification
REQ-033 Normal save, SECTOR_NUM=4, wr_busy model high 3 cycles after wr_en, low after 20: key_flag, frame_start -> wr_addr 1000..1003, four wr_en pulses, save_done once, sec_cnt=4, src_sel 0 afterwards.
REQ-034 key_flag with sd_init_end=0 -> state stays IDLE, no wr_en, src_sel=0.
REQ-035 wr_busy never rises, BUSY_TMO=10 -> save_err=1 on cycle 10 after wr_en, src_sel=0, no save_done; next key_flag clears save_err.
REQ-036 wr_busy held high when entering ISSUE -> no wr_en until wr_busy low, then single wr_en.
REQ-037 sys_rst asserted during WAIT_LO of sector 2 -> all outputs 0 next cycle, no save_done; subsequent save restarts at wr_addr 1000.
REQ-038 Second key_flag and extra frame_start during a save -> ignored, total wr_en count equals SECTOR_NUM.
